// File: rtl/uart_oversample.sv
// Full-duplex UART core: 16x oversampled RX with majority vote, configurable frame, runtime divider.
// Optional internal TX->RX loopback is compiled in when UART_LOOPBACK_EN is defined.
module uart_oversample #(
    parameter int CLOCK_RATE   = 50000000,
    parameter int DEFAULT_BAUD = 115200,
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ack,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    input  logic                 set_clock_div,
    input  logic [DIV_WIDTH-1:0] user_clock_div,
    output logic [DIV_WIDTH-1:0] clock_div,
    output logic                 rx_busy,
    output logic                 tx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clr,
    input  logic                 loopback
);
    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(CLOCK_RATE / (OVERSAMPLE * DEFAULT_BAUD) - 1);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

    tx_state_t            tx_state_q, tx_state_d;
    logic [DIV_WIDTH-1:0] clock_div_q, clock_div_d, tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_tick_q, tx_tick_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d, tx_en_par_q, tx_en_par_d, tx_two_q, tx_two_d;
    logic                 tx_q, tx_d, tx_tick, tx_bit_end;

    rx_state_t            rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_tick_q, rx_tick_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [1:0]           rx_pmode_q, rx_pmode_d;
    logic                 rx_meta_q, rx_sync_q, rx_in;
    logic                 rx_v7_q, rx_v7_d, rx_v8_q, rx_v8_d, rx_par_bad_q, rx_par_bad_d;
    logic                 rx_valid_q, rx_valid_d, ferr_q, ferr_d, perr_q, perr_d, ovr_q, ovr_d;
    logic                 rx_tick, rx_sample, rx_bit_end, rx_maj, deliver, ferr_set;

`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    assign clock_div     = clock_div_q;
    assign tx_busy       = (tx_state_q != TX_IDLE);
    assign tx_ready      = (tx_state_q == TX_IDLE);
    assign rx_busy       = (rx_state_q != RX_IDLE);
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_frame_err  = ferr_q;
    assign rx_parity_err = perr_q;
    assign rx_overrun    = ovr_q;

    always_comb begin
        clock_div_d = set_clock_div ? user_clock_div : clock_div_q;
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_en_par_d = tx_en_par_q;
        tx_two_d    = tx_two_q;
        tx_tick     = (tx_cnt_q == '0);
        tx_bit_end  = tx_tick && (tx_tick_q == LAST_TICK);
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? clock_div_q : tx_cnt_q - 1'b1;
            if (tx_tick) tx_tick_d = tx_tick_q + 4'd1;
        end
        case (tx_state_q)
            TX_IDLE: if (tx_start) begin
                tx_state_d  = TX_START;
                tx_cnt_d    = clock_div_q;
                tx_tick_d   = '0;
                tx_shift_d  = tx_data;
                tx_par_d    = (^tx_data) ^ (parity_mode == 2'b10);
                tx_en_par_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                tx_two_d    = two_stop;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == LAST_BIT) begin
                    tx_state_d = tx_en_par_q ? TX_PARITY : TX_STOP;
                    tx_bit_d   = '0;
                end
            end
            TX_PARITY: if (tx_bit_end) begin
                tx_state_d = TX_STOP;
                tx_bit_d   = '0;
            end
            TX_STOP: if (tx_bit_end) begin
                if (tx_two_q && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
                else tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (set_clock_div) tx_state_d = TX_IDLE;
        // Line level is registered from the next state so it changes on the same edge as the state.
        case (tx_state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = tx_shift_d[0];
            TX_PARITY: tx_d = tx_par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_tick_d    = rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_pmode_d   = rx_pmode_q;
        rx_v7_d      = rx_v7_q;
        rx_v8_d      = rx_v8_q;
        rx_par_bad_d = rx_par_bad_q;
        deliver      = 1'b0;
        ferr_set     = 1'b0;
        rx_tick      = (rx_cnt_q == '0);
        rx_sample    = rx_tick && (rx_tick_q == 4'd9);
        rx_bit_end   = rx_tick && (rx_tick_q == LAST_TICK);
        rx_maj       = (rx_v7_q & rx_v8_q) | (rx_v7_q & rx_sync_q) | (rx_v8_q & rx_sync_q);
        if (rx_state_q != RX_IDLE && rx_state_q != RX_WAIT_HIGH) begin
            rx_cnt_d = rx_tick ? clock_div_q : rx_cnt_q - 1'b1;
            if (rx_tick) rx_tick_d = rx_tick_q + 4'd1;
            if (rx_tick && rx_tick_q == 4'd7) rx_v7_d = rx_sync_q;
            if (rx_tick && rx_tick_q == 4'd8) rx_v8_d = rx_sync_q;
        end
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_state_d   = RX_START;
                rx_cnt_d     = clock_div_q;
                rx_tick_d    = '0;
                rx_pmode_d   = parity_mode;
                rx_par_bad_d = 1'b0;
            end
            RX_START: begin
                if (rx_sample && rx_maj) rx_state_d = RX_IDLE;
                else if (rx_bit_end) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_sample) rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
                if (rx_bit_end) begin
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == LAST_BIT)
                        rx_state_d = (rx_pmode_q == 2'b01 || rx_pmode_q == 2'b10) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (rx_sample) rx_par_bad_d = ((^rx_shift_q) ^ rx_maj) != (rx_pmode_q == 2'b10);
                if (rx_bit_end) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_sample) begin
                deliver    = rx_maj;
                ferr_set   = !rx_maj;
                rx_state_d = rx_maj ? RX_IDLE : RX_WAIT_HIGH;
            end
            RX_WAIT_HIGH: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
        if (set_clock_div) begin
            rx_state_d = RX_IDLE;
            deliver    = 1'b0;
            ferr_set   = 1'b0;
        end
        rx_valid_d = rx_valid_q && !rx_ack;
        rx_data_d  = rx_data_q;
        ovr_d      = ovr_q && !err_clr;
        // An ack in the delivery cycle frees the holding register, so the new byte is kept.
        if (deliver) begin
            if (rx_valid_d) ovr_d = 1'b1;
            else begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
            end
        end
        perr_d = (perr_q && !err_clr) || (deliver && rx_par_bad_q);
        ferr_d = (ferr_q && !err_clr) || ferr_set;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clock_div_q <= DEFAULT_DIV;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_en_par_q <= 1'b0;
            tx_two_q    <= 1'b0;
            tx_q        <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_pmode_q  <= '0;
            rx_v7_q     <= 1'b1;
            rx_v8_q     <= 1'b1;
            rx_par_bad_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            clock_div_q <= clock_div_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_en_par_q <= tx_en_par_d;
            tx_two_q    <= tx_two_d;
            tx_q        <= tx_d;
            rx_meta_q   <= rx_in;
            rx_sync_q   <= rx_meta_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_pmode_q  <= rx_pmode_d;
            rx_v7_q     <= rx_v7_d;
            rx_v8_q     <= rx_v8_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            ovr_q       <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_oversample.sv
// Bench for uart_oversample: randomized TX/RX frames checked against a frame-level model.
// Loopback checks are included when UART_LOOPBACK_EN is defined.
module tb_uart_oversample;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic        tx;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ack = 1'b0;
    logic [1:0]  parity_mode = '0;
    logic        two_stop = 1'b0;
    logic        set_clock_div = 1'b0;
    logic [15:0] user_clock_div = '0;
    logic [15:0] clock_div;
    logic        rx_busy, tx_busy, rx_frame_err, rx_parity_err, rx_overrun;
    logic        err_clr = 1'b0;
    logic        loopback = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int div     = 26;

    // Model of the receive side: exp_q holds the byte expected in the RX holding register.
    logic [7:0] exp_q[$];
    logic       m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    uart_oversample dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .tx_start(tx_start), .tx_data(tx_data),
        .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ack(rx_ack),
        .parity_mode(parity_mode), .two_stop(two_stop), .set_clock_div(set_clock_div),
        .user_clock_div(user_clock_div), .clock_div(clock_div), .rx_busy(rx_busy),
        .tx_busy(tx_busy), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun), .err_clr(err_clr), .loopback(loopback)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic has_par(input logic [1:0] pm);
        return (pm == 2'b01) || (pm == 2'b10);
    endfunction

    // Parity bit that makes the total count of ones even (01) or odd (10).
    function automatic logic par_bit(input logic [7:0] d, input logic [1:0] pm);
        logic odd_ones;
        odd_ones = ($countones(d) % 2) == 1;
        return (pm == 2'b10) ? !odd_ones : odd_ones;
    endfunction

    task automatic set_div(input int v);
        @(negedge clk);
        user_clock_div = 16'(v);
        set_clock_div  = 1'b1;
        @(negedge clk);
        set_clock_div = 1'b0;
        div = v;
        check_eq("clock_div", clock_div, 32'(v));
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_q.delete();
        check_eq("ack_clears_valid", rx_valid, 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic check_rx_state(input string tag);
        check_eq({tag, "_valid"}, rx_valid, (exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq({tag, "_data"}, rx_data, exp_q[0]);
        check_eq({tag, "_perr"}, rx_parity_err, m_perr);
        check_eq({tag, "_ferr"}, rx_frame_err, m_ferr);
        check_eq({tag, "_ovr"}, rx_overrun, m_ovr);
        check_eq({tag, "_busy"}, rx_busy, 0);
    endtask

    // Send one frame through the TX path and compare the line against the bit list every bit.
    task automatic tx_frame(input logic [7:0] d, input logic [1:0] pm, input logic two);
        logic bits[$];
        int p, n;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (has_par(pm)) bits.push_back(par_bit(d, pm));
        bits.push_back(1'b1);
        if (two) bits.push_back(1'b1);
        p = (div + 1) * 16;
        n = bits.size() * p;
        check_eq("tx_ready_before", tx_ready, 1);
        tx_data = d; parity_mode = pm; two_stop = two; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (c % p == 0 || c % p == p / 2 || c % p == p - 1) check_eq("tx_bit", tx, bits[c / p]);
            if (c == 0 || c == n - 1) check_eq("tx_ready_low", tx_ready, 0);
            @(negedge clk);
        end
        check_eq("tx_ready_back", tx_ready, 1);
        check_eq("tx_idle_high", tx, 1);
    endtask

    // Drive one serial frame on rx, then update the model and compare.
    task automatic rx_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                            input logic bad_par, input logic bad_stop);
        logic bits[$];
        int p;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (has_par(pm)) bits.push_back(par_bit(d, pm) ^ bad_par);
        bits.push_back(!bad_stop);
        if (two) bits.push_back(1'b1);
        bits.push_back(1'b1);
        p = (div + 1) * 16;
        parity_mode = pm;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (p) @(negedge clk);
        end
        if (bad_stop) m_ferr = 1'b1;
        else begin
            if (has_par(pm) && bad_par) m_perr = 1'b1;
            if (exp_q.size() != 0) m_ovr = 1'b1;
            else exp_q.push_back(d);
        end
        check_rx_state("rx");
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] pm;
        logic       bp, bs;
        int         r, p;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
        check_eq("rst_busy", {rx_busy, tx_busy}, 0);
        check_eq("rst_clock_div", clock_div, 26);
        rst = 1'b1;
        @(negedge clk);

        set_div(1);
        tx_frame(8'hA5, 2'b00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            tx_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        rx_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b0);
        pulse_ack();
        rx_frame(8'h3C, 2'b01, 1'b1, 1'b1, 1'b0);
        pulse_ack();
        pulse_clr();
        check_rx_state("clr");

        rx_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b0);
        rx_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b0);
        pulse_ack();
        pulse_clr();
        check_rx_state("ovr_clr");

        rx_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1);
        pulse_clr();

        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("glitch_busy", rx_busy, 1);
        repeat (3 * (div + 1) * 16) @(negedge clk);
        check_rx_state("glitch");

        for (int i = 0; i < 16; i++) begin
            if (i == 8) set_div(2);
            d  = 8'($urandom_range(0, 255));
            pm = 2'($urandom_range(0, 3));
            bs = ($urandom_range(0, 5) == 0);
            bp = (exp_q.size() == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            rx_frame(d, pm, 1'($urandom_range(0, 1)), bp, bs);
            r = $urandom_range(0, 3);
            if (r[0]) pulse_ack();
            if (r[1]) pulse_clr();
        end
        set_div(1);

        // Divider load aborts both directions mid-frame.
        tx_data = 8'h00; parity_mode = 2'b00; two_stop = 1'b0; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        rx = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("abort_tx_busy", tx_busy, 1);
        check_eq("abort_rx_busy", rx_busy, 1);
        user_clock_div = 16'd2;
        set_clock_div  = 1'b1;
        @(negedge clk);
        set_clock_div = 1'b0;
        div = 2;
        check_eq("abort_tx_idle", {tx, tx_ready, tx_busy}, 3'b110);
        check_eq("abort_rx_idle", rx_busy, 0);
        check_eq("abort_div", clock_div, 2);
        rx = 1'b1;
        repeat (2 * (div + 1) * 16) @(negedge clk);
        check_rx_state("abort");

        user_clock_div = 16'd1;
        set_clock_div  = 1'b1;
        tx_start       = 1'b1;
        @(negedge clk);
        set_clock_div = 1'b0;
        tx_start      = 1'b0;
        div = 1;
        repeat (3) @(negedge clk);
        check_eq("setdiv_wins_ready", tx_ready, 1);
        check_eq("setdiv_wins_tx", tx, 1);

        rx_frame(8'h96, 2'b00, 1'b0, 1'b0, 1'b0);
        tx_data = 8'h00; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_eq("mid_rst_tx", {tx, tx_ready}, 2'b11);
        check_eq("mid_rst_div", clock_div, 26);
        check_eq("mid_rst_data", rx_data, 0);
        check_rx_state("mid_rst");
        set_div(1);

`ifdef UART_LOOPBACK_EN
        loopback = 1'b1;
        parity_mode = 2'b00; two_stop = 1'b0;
        tx_data = 8'h55; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        p = 0;
        repeat (11 * (div + 1) * 16) begin
            if (tx !== 1'b1) p++;
            @(negedge clk);
        end
        check_eq("lb_tx_pin_high", p, 0);
        check_eq("lb_valid", rx_valid, 1);
        check_eq("lb_data", rx_data, 8'h55);
        loopback = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
